// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage
//
// Owns the program counter, drives the address of a combinational instruction
// ROM and registers the returned word into an instruction register for the
// decoder. Handles branch redirects (one-bubble squash), decoder stalls and
// program halt.
//
// Ports
//   Clk          in   clock, all state updates on posedge
//   Reset_n      in   synchronous active-low reset, highest priority
//   Start        in   one-cycle pulse, starts fetching at START_ADDR
//   InstAddress  out  ROM address (the PC register itself)
//   InstIn       in   ROM word at InstAddress, same cycle
//   Stall        in   decoder not ready, hold Inst/InstValid/PC
//   BranchEn     in   redirect request
//   BranchTarget in   absolute redirect address
//   Inst         out  registered instruction
//   InstPC       out  address Inst was fetched from
//   InstValid    out  Inst holds a live instruction
//   Done         out  high while halted
//   FetchCount   out  (FETCH_COUNT_EN only) saturating count of issued words
//
// Optional feature macro: FETCH_COUNT_EN
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int          A          = 10,
  parameter int          W          = 9,
  parameter logic [A-1:0] START_ADDR = '0,
  parameter logic [W-1:0] HALT_WORD  = {W{1'b1}}
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  output logic [A-1:0] InstAddress,
  input  logic [W-1:0] InstIn,
  input  logic         Stall,
  input  logic         BranchEn,
  input  logic [A-1:0] BranchTarget,
  output logic [W-1:0] Inst,
  output logic [A-1:0] InstPC,
  output logic         InstValid,
  output logic         Done
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]  FetchCount
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [A-1:0]   pc_q, pc_d;
  logic [W-1:0]   inst_q, inst_d;
  logic [A-1:0]   inst_pc_q, inst_pc_d;
  logic           vld_q, vld_d;
`ifdef FETCH_COUNT_EN
  logic [15:0]    count_q, count_d;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      inst_q    <= '0;
      inst_pc_q <= '0;
      vld_q     <= 1'b0;
`ifdef FETCH_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      vld_q     <= vld_d;
`ifdef FETCH_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    vld_d     = vld_q;
`ifdef FETCH_COUNT_EN
    count_d   = count_q;
`endif
    unique case (state_q)
      FETCH: begin
        if (BranchEn) begin
          // Redirect wins over stall; the word currently at PC is dropped.
          pc_d  = BranchTarget;
          vld_d = 1'b0;
        end else if (Stall) begin
          // Everything holds.
        end else if (InstIn == HALT_WORD) begin
          // PC parks on the halt address; halt word never reaches decode.
          state_d = HALTED;
          vld_d   = 1'b0;
        end else begin
          inst_d    = InstIn;
          inst_pc_d = pc_q;
          vld_d     = 1'b1;
          pc_d      = pc_q + A'(1);
`ifdef FETCH_COUNT_EN
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
`endif
        end
      end
      default: begin
        // IDLE and HALTED: only Start is honoured.
        vld_d = 1'b0;
        if (Start) begin
          state_d = FETCH;
          pc_d    = START_ADDR;
`ifdef FETCH_COUNT_EN
          count_d = '0;
`endif
        end
      end
    endcase
  end

  assign InstAddress = pc_q;
  assign Inst        = inst_q;
  assign InstPC      = inst_pc_q;
  assign InstValid   = vld_q;
  assign Done        = (state_q == HALTED);
`ifdef FETCH_COUNT_EN
  assign FetchCount  = count_q;
`endif

endmodule
